// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU control unit: opcodes, ALU op codes,
// sequencer state encoding, instruction classes and the strobe bundle.
// Optional macro MUL_DIV_EN: when defined, mul/div decode to their own
// multi-step class; otherwise they fall through to nop.
package mini_cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_NEG  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10100;
    localparam logic [4:0] OP_OUT  = 5'b10101;
    localparam logic [4:0] OP_MFHI = 5'b10110;
    localparam logic [4:0] OP_MFLO = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The ALU is driven with the opcode itself; address arithmetic uses add.
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = OP_ADD;

    typedef enum logic [3:0] {
        S_FETCH0 = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_T3     = 4'd3,
        S_T4     = 4'd4,
        S_T5     = 4'd5,
        S_T6     = 4'd6,
        S_T7     = 4'd7,
        S_PAUSE  = 4'd8,
        S_HALT   = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_HALT, CL_MULDIV
    } iclass_e;

    typedef struct packed {
        logic       Gra, Grb, Grc, Rin, Rout, BAout;
        logic       PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
        logic       Yin, Zin, Zlowout, Zhighout, Cout;
        logic       HIin, LOin, HIout, LOout, CONin, InPortout, OutPortin;
        logic [4:0] alu_op;
        logic       run;
    } ctrl_t;

    // Map an opcode onto the execute sequence it follows; unknown codes are nop.
    function automatic iclass_e op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_NEG, OP_NOT:   return CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:         return CL_IMM;
            OP_LD:                            return CL_LD;
            OP_LDI:                           return CL_LDI;
            OP_ST:                            return CL_ST;
            OP_BR:                            return CL_BR;
            OP_JR:                            return CL_JR;
            OP_MFHI:                          return CL_MFHI;
            OP_MFLO:                          return CL_MFLO;
            OP_IN:                            return CL_IN;
            OP_OUT:                           return CL_OUT;
            OP_HALT:                          return CL_HALT;
`ifdef MUL_DIV_EN
            OP_MUL, OP_DIV:                   return CL_MULDIV;
`endif
            default:                          return CL_NOP;
        endcase
    endfunction

    // Final execute step of each class; after it the sequencer refetches.
    function automatic state_e last_step(input iclass_e cls);
        case (cls)
            CL_ALU, CL_IMM, CL_LDI: return S_T5;
            CL_BR, CL_MULDIV:       return S_T6;
            CL_LD, CL_ST:           return S_T7;
            default:                return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: decode inputs,
// memory handshake, pause request and every control strobe.
interface control_sequencer_if;
    logic [4:0] opcode;
    logic       con_ff;
    logic       mem_ready;
    logic       stop;

    logic       Gra, Grb, Grc, Rin, Rout, BAout;
    logic       PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write;
    logic       Yin, Zin, Zlowout, Zhighout, Cout;
    logic       HIin, LOin, HIout, LOout, CONin, InPortout, OutPortin;
    logic [4:0] alu_op;
    logic       run;

    modport master (
        input  opcode, con_ff, mem_ready, stop,
        output Gra, Grb, Grc, Rin, Rout, BAout,
               PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
               Yin, Zin, Zlowout, Zhighout, Cout,
               HIin, LOin, HIout, LOout, CONin, InPortout, OutPortin,
               alu_op, run
    );

    modport slave (
        output opcode, con_ff, mem_ready, stop,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
               PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write,
               Yin, Zin, Zlowout, Zhighout, Cout,
               HIin, LOin, HIout, LOout, CONin, InPortout, OutPortin,
               alu_op, run
    );
endinterface

// File: rtl/cs_output_decode.sv
// Combinational strobe map for the control sequencer: (state, opcode,
// con_ff) -> control bundle. Holds no state.
// Optional macro MUL_DIV_EN: enables the mul/div execute steps; without it
// Zhighout, HIin and LOin are held at 0.
module cs_output_decode
    import mini_cpu_pkg::*;
(
    input  state_e     state_i,
    input  logic [4:0] opcode_i,
    input  logic       con_ff_i,
    output ctrl_t      ctrl_o
);
    iclass_e cls;
    assign cls = op_class(opcode_i);

    // Strobes for the current step; everything not named stays 0.
    always_comb begin
        ctrl_o     = '0;
        ctrl_o.run = 1'b1;
        case (state_i)
            S_FETCH0: begin
                ctrl_o.PCout = 1'b1; ctrl_o.MARin = 1'b1;
                ctrl_o.IncPC = 1'b1; ctrl_o.Zin   = 1'b1;
            end
            S_FETCH1: begin
                ctrl_o.Zlowout = 1'b1; ctrl_o.PCin  = 1'b1;
                ctrl_o.Read    = 1'b1; ctrl_o.MDRin = 1'b1;
            end
            S_FETCH2: begin
                ctrl_o.MDRout = 1'b1; ctrl_o.IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CL_ALU, CL_IMM: begin
                        ctrl_o.Grb = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.Yin = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        ctrl_o.Grb = 1'b1; ctrl_o.BAout = 1'b1; ctrl_o.Yin = 1'b1;
                    end
                    CL_BR: begin
                        ctrl_o.Gra = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.CONin = 1'b1;
                    end
                    CL_JR: begin
                        ctrl_o.Gra = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.PCin = 1'b1;
                    end
                    CL_MFHI: begin
                        ctrl_o.HIout = 1'b1; ctrl_o.Gra = 1'b1; ctrl_o.Rin = 1'b1;
                    end
                    CL_MFLO: begin
                        ctrl_o.LOout = 1'b1; ctrl_o.Gra = 1'b1; ctrl_o.Rin = 1'b1;
                    end
                    CL_IN: begin
                        ctrl_o.InPortout = 1'b1; ctrl_o.Gra = 1'b1; ctrl_o.Rin = 1'b1;
                    end
                    CL_OUT: begin
                        ctrl_o.Gra = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.OutPortin = 1'b1;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        ctrl_o.Gra = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.Yin = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_ALU: begin
                        ctrl_o.Grc = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.Zin = 1'b1;
                        ctrl_o.alu_op = opcode_i;
                    end
                    CL_IMM: begin
                        ctrl_o.Cout = 1'b1; ctrl_o.Zin = 1'b1;
                        ctrl_o.alu_op = opcode_i;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        ctrl_o.Cout = 1'b1; ctrl_o.Zin = 1'b1;
                        ctrl_o.alu_op = ALU_ADD;
                    end
                    CL_BR: begin
                        ctrl_o.PCout = 1'b1; ctrl_o.Yin = 1'b1;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        ctrl_o.Grb = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.Zin = 1'b1;
                        ctrl_o.alu_op = opcode_i;
                    end
`endif
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_ALU, CL_IMM, CL_LDI: begin
                        ctrl_o.Zlowout = 1'b1; ctrl_o.Gra = 1'b1; ctrl_o.Rin = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        ctrl_o.Zlowout = 1'b1; ctrl_o.MARin = 1'b1;
                    end
                    CL_BR: begin
                        ctrl_o.Cout = 1'b1; ctrl_o.Zin = 1'b1;
                        ctrl_o.alu_op = ALU_ADD;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        ctrl_o.Zlowout = 1'b1; ctrl_o.LOin = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_LD: begin
                        ctrl_o.Read = 1'b1; ctrl_o.MDRin = 1'b1;
                    end
                    CL_ST: begin
                        ctrl_o.Gra = 1'b1; ctrl_o.Rout = 1'b1; ctrl_o.MDRin = 1'b1;
                    end
                    CL_BR: begin
                        // Target sits in Z; only a taken branch loads it.
                        ctrl_o.Zlowout = 1'b1; ctrl_o.PCin = con_ff_i;
                    end
`ifdef MUL_DIV_EN
                    CL_MULDIV: begin
                        ctrl_o.Zhighout = 1'b1; ctrl_o.HIin = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD: begin
                        ctrl_o.MDRout = 1'b1; ctrl_o.Gra = 1'b1; ctrl_o.Rin = 1'b1;
                    end
                    CL_ST: ctrl_o.Write = 1'b1;
                    default: ;
                endcase
            end
            S_PAUSE, S_HALT: ctrl_o.run = 1'b0;
            default: ;
        endcase
`ifndef MUL_DIV_EN
        ctrl_o.Zhighout = 1'b0;
        ctrl_o.HIin     = 1'b0;
        ctrl_o.LOin     = 1'b0;
`endif
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the mini CPU: fetch, per-class execute
// steps, pause and halt. Holds the state register and next-state logic;
// strobes come from cs_output_decode.
// Optional macro MUL_DIV_EN: adds the mul/div execute sequence (see package).
module control_sequencer
    import mini_cpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    control_sequencer_if.master bus
);
    state_e  state_q, state_d;
    state_e  last_st;
    iclass_e cls;
    ctrl_t   dec;
    ctrl_t   ctrl;

    assign cls     = op_class(bus.opcode);
    assign last_st = last_step(cls);

    // State register; reset aborts any instruction, including a memory wait.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH0;
        else          state_q <= state_d;
    end

    // Next state: memory waits hold only in FETCH1, ld T6 and st T7.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH0: state_d = bus.stop ? S_PAUSE : S_FETCH1;
            S_FETCH1: if (bus.mem_ready) state_d = S_FETCH2;
            S_FETCH2: state_d = S_T3;
            S_T3: begin
                if (cls == CL_HALT)        state_d = S_HALT;
                else if (last_st == S_T3)  state_d = S_FETCH0;
                else                       state_d = S_T4;
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = (last_st == S_T5) ? S_FETCH0 : S_T6;
            S_T6: begin
                if (cls == CL_LD && !bus.mem_ready) state_d = S_T6;
                else if (last_st == S_T6)           state_d = S_FETCH0;
                else                                state_d = S_T7;
            end
            S_T7: begin
                if (cls == CL_ST && !bus.mem_ready) state_d = S_T7;
                else                                state_d = S_FETCH0;
            end
            S_PAUSE: if (!bus.stop) state_d = S_FETCH0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH0;
        endcase
    end

    cs_output_decode u_decode (
        .state_i  (state_q),
        .opcode_i (bus.opcode),
        .con_ff_i (bus.con_ff),
        .ctrl_o   (dec)
    );

    // Silence strobes while reset is held and when FETCH0 diverts to PAUSE.
    always_comb begin
        ctrl = dec;
        if (!reset_n || (state_q == S_FETCH0 && bus.stop)) begin
            ctrl     = '0;
            ctrl.run = 1'b1;
        end
    end

    assign bus.Gra       = ctrl.Gra;
    assign bus.Grb       = ctrl.Grb;
    assign bus.Grc       = ctrl.Grc;
    assign bus.Rin       = ctrl.Rin;
    assign bus.Rout      = ctrl.Rout;
    assign bus.BAout     = ctrl.BAout;
    assign bus.PCout     = ctrl.PCout;
    assign bus.PCin      = ctrl.PCin;
    assign bus.IncPC     = ctrl.IncPC;
    assign bus.IRin      = ctrl.IRin;
    assign bus.MARin     = ctrl.MARin;
    assign bus.MDRin     = ctrl.MDRin;
    assign bus.MDRout    = ctrl.MDRout;
    assign bus.Read      = ctrl.Read;
    assign bus.Write     = ctrl.Write;
    assign bus.Yin       = ctrl.Yin;
    assign bus.Zin       = ctrl.Zin;
    assign bus.Zlowout   = ctrl.Zlowout;
    assign bus.Zhighout  = ctrl.Zhighout;
    assign bus.Cout      = ctrl.Cout;
    assign bus.HIin      = ctrl.HIin;
    assign bus.LOin      = ctrl.LOin;
    assign bus.HIout     = ctrl.HIout;
    assign bus.LOout     = ctrl.LOout;
    assign bus.CONin     = ctrl.CONin;
    assign bus.InPortout = ctrl.InPortout;
    assign bus.OutPortin = ctrl.OutPortin;
    assign bus.alu_op    = ctrl.alu_op;
    assign bus.run       = ctrl.run;

endmodule
